multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
Sequencing FSM that turns the MIPS datapath into a multi-cycle machine sharing one memory port and one ALU across instruction phases. Each instruction is split into fetch, decode, execute, memory and writeback steps. The block sits beside the register file, ALU control and shared memory, and drives their enables and mux selects. It decodes ins[0:5] (opcode) and ins[26:31] (funct) from the instruction register, and stalls on a memory-ready handshake.

Parameters:
OP_W, 6, opcode/funct field width
ST_W, 4, state register width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
opcode  in  6  IR bits 0:5
funct  in  6  IR bits 26:31
mem_ready  in  1  shared memory completed current read/write this cycle
zero  in  1  ALU zero flag (valid in BRANCH state)
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if branch condition holds
branch_ne  out  1  1 = bne (invert zero), 0 = beq
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  load instruction register
reg_dst  out  2  0 = rt, 1 = rd, 2 = r31
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = rs
alu_src_b  out  2  0 = rt, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
alu_op  out  2  0 = add, 1 = sub, 2 = funct-decode
pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target, 3 = rs (jr)
illegal_op  out  1  one-cycle pulse on unsupported opcode/funct
state  out  4  current state (debug)

Behaviour:
- State register updates on rising clk; reset=1 forces state=FETCH next edge. While reset=1 all enables (pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, illegal_op) are 0; selects are 0.
- Outputs are Moore-decoded from state. Exception: pc_write and ir_write in FETCH are gated by mem_ready.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_source=0. Stays in FETCH until mem_ready=1; on that cycle ir_write=1 and pc_write=1 (PC+4), next state DECODE.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=0 (precompute branch target). Next state by opcode:
  - 000000: funct 001000 -> JR; any other funct -> EXEC_R.
  - 100011 / 101011 -> MEMADR.
  - 000100 / 000101 -> BRANCH.
  - 000010 -> JUMP.
  - 001000 -> EXEC_I.
  - anything else -> ILLEGAL.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next MEMRD for lw, MEMWR for sw.
- MEMRD: mem_read=1, iord=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next FETCH.
- MEMWR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op=2. Next RWB.
- RWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2, alu_op=0. Next IWB.
- IWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_source=1, branch_ne=opcode[5]. Next FETCH.
- JUMP: pc_write=1, pc_source=2. Next FETCH.
- JR: pc_write=1, pc_source=3. Next FETCH.
- ILLEGAL: illegal_op=1 for exactly one cycle. PC keeps the PC+4 value from FETCH. Next FETCH.
- Cycle counts with mem_ready tied high:
  - lw 5; sw 4; R-type 4; addi 4; beq/bne 3; j/jr 3; illegal 3.
  - Each extra wait cycle in FETCH/MEMRD/MEMWR adds 1.
- mem_read and mem_write are never both 1. reg_write and a memory write are never both 1.
- opcode/funct are sampled only in DECODE/MEMADR and must stay stable after ir_write until the next FETCH.
- Reset asserted in any state (including mid-wait in MEMRD/MEMWR) aborts the instruction: no further writes, FETCH after release.
- Undefined state encodings go to FETCH with all enables 0.

Decomposition:
- Package mc_pkg: state encodings (FETCH=0 … ILLEGAL=13), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI), FUNCT_JR, alu_op codes, alu_src_b and pc_source select codes.
- One combinational sub-module, mc_output_decode: state + mem_ready + opcode -> all control outputs.
- Top module holds the state register and next-state logic.

Test Plan:
- lw, opcode 100011, mem_ready=1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; reg_write=1 with mem_to_reg=1 only in cycle 5.
- sw, mem_ready low for 3 cycles in MEMWR -> mem_write=1 held for 4 cycles, iord=1; FETCH on cycle 8; reg_write never 1.
- beq vs bne (000100 / 000101), zero=1 -> 3 cycles each; pc_write_cond=1 with pc_source=1; branch_ne=0 then 1.
- R-type funct 100000 then funct 001000 -> first: EXEC_R alu_op=2, RWB reg_dst=1; second: JR, pc_write=1, pc_source=3, reg_write never 1.
- FETCH with mem_ready=0 for 2 cycles -> ir_write/pc_write stay 0; both pulse 1 on the mem_ready cycle only.
- Reset in MEMRD, then opcode 111111 -> after release FETCH, no reg_write; illegal opcode gives illegal_op=1 for one cycle, then FETCH.

Source files
------------

// File: rtl/mc_pkg.sv
// ============================================================================
// mc_pkg: state encodings, instruction field constants and select codes
//         shared by the multi-cycle MIPS control unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_MEMADR  = 4'd2,
        ST_MEMRD   = 4'd3,
        ST_MEMWB   = 4'd4,
        ST_MEMWR   = 4'd5,
        ST_EXEC_R  = 4'd6,
        ST_RWB     = 4'd7,
        ST_EXEC_I  = 4'd8,
        ST_IWB     = 4'd9,
        ST_BRANCH  = 4'd10,
        ST_JUMP    = 4'd11,
        ST_JR      = 4'd12,
        ST_ILLEGAL = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_RT      = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_IMM     = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal_op;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/mc_output_decode.sv
// ============================================================================
// mc_output_decode: Moore control decode of the current state; only the
//                   FETCH-phase IR/PC loads depend on mem_ready.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mc_output_decode
    import mc_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic       mem_ready,
    input  logic [5:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        if (!reset) begin
            case (state)
                ST_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                ST_DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ST_MEMADR, ST_EXEC_I: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                ST_MEMRD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                end
                ST_MEMWB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.reg_dst    = REGDST_RT;
                    ctrl.mem_to_reg = 1'b1;
                end
                ST_MEMWR: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                end
                ST_EXEC_R: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_RT;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                ST_RWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = REGDST_RD;
                end
                ST_IWB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = REGDST_RT;
                end
                ST_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_RT;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                    // Only beq/bne reach here, so this equals the opcode LSB
                    ctrl.branch_ne     = (opcode == OP_BNE);
                end
                ST_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                ST_JR: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_RS;
                end
                ST_ILLEGAL: begin
                    ctrl.illegal_op = 1'b1;
                end
                default: begin
                    ctrl = '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: sequencing FSM for a multi-cycle MIPS datapath sharing
//                     one memory port and one ALU across instruction phases.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] opcode,
    input  logic [OP_W-1:0] funct,
    input  logic            mem_ready,
    input  logic            zero,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            branch_ne,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic [1:0]      reg_dst,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t r_state;
    state_t w_next;
    ctrl_t  w_ctrl;
    logic   w_unused_zero;

    // The branch decision is resolved in the PC write-enable logic outside
    assign w_unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     w_next = (funct == FUNCT_JR) ? ST_JR : ST_EXEC_R;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ,
                    OP_BNE:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_EXEC_I;
                    default:      w_next = ST_ILLEGAL;
                endcase
            end
            ST_MEMADR: w_next = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC_R: w_next = ST_RWB;
            ST_EXEC_I: w_next = ST_IWB;
            // Writeback, branch/jump, illegal and undefined encodings all end here
            default:   w_next = ST_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .reset     (reset),
        .state     (r_state),
        .mem_ready (mem_ready),
        .opcode    (opcode),
        .ctrl      (w_ctrl)
    );

    assign pc_write      = w_ctrl.pc_write;
    assign pc_write_cond = w_ctrl.pc_write_cond;
    assign branch_ne     = w_ctrl.branch_ne;
    assign iord          = w_ctrl.iord;
    assign mem_read      = w_ctrl.mem_read;
    assign mem_write     = w_ctrl.mem_write;
    assign ir_write      = w_ctrl.ir_write;
    assign reg_dst       = w_ctrl.reg_dst;
    assign mem_to_reg    = w_ctrl.mem_to_reg;
    assign reg_write     = w_ctrl.reg_write;
    assign alu_src_a     = w_ctrl.alu_src_a;
    assign alu_src_b     = w_ctrl.alu_src_b;
    assign alu_op        = w_ctrl.alu_op;
    assign pc_source     = w_ctrl.pc_source;
    assign illegal_op    = w_ctrl.illegal_op;
    assign state         = r_state;

endmodule

`default_nettype wire
